// File: rtl/jpeg_pkg.sv
// Shared constants for the 8x8 block sequencer: block geometry and lane slicing.
package jpeg_pkg;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned ROW_IDX_W = 3;
  localparam int unsigned DEF_PIX_W = 8;

  // Lane 0 is the MSB lane, so lane k starts pix_w*(ROWS-1-k) bits up.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned pix_w);
    return pix_w * (ROWS - 1 - lane);
  endfunction

endpackage

// File: rtl/jpeg_blk_bank.sv
// One 8x8 pixel bank: row write port plus simultaneous row and column read of one index.
module jpeg_blk_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [ROW_IDX_W-1:0]     wr_row_i,
  input  logic [ROWS*PIX_W-1:0]    wr_data_i,
  input  logic [ROW_IDX_W-1:0]     rd_idx_i,
  output logic [ROWS*PIX_W-1:0]    rd_row_o,
  output logic [ROWS*PIX_W-1:0]    rd_col_o
);

  logic [ROWS*PIX_W-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  // Column c: lane k comes from lane c of stored row k.
  always_comb begin
    rd_row_o = mem_q[rd_idx_i];
    rd_col_o = '0;
    for (int k = 0; k < ROWS; k++) begin
      rd_col_o[lane_lsb(k, PIX_W) +: PIX_W] = mem_q[k][lane_lsb(int'(rd_idx_i), PIX_W) +: PIX_W];
    end
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Double-buffered 8x8 block sequencer: rows in, rows or columns out, with frame framing.
module jpeg_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int unsigned PIX_W         = DEF_PIX_W,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned BLK_PER_FRAME = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS*PIX_W-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     transpose,
  output logic [ROWS*PIX_W-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_IDX_W-1:0]     out_row,
  output logic [ADDR_W-4:0]        out_blk,
  output logic                     out_sob,
  output logic                     out_eob,
  output logic                     out_eof,
  output logic [ADDR_W-1:0]        in_addr
);

  localparam int unsigned RowW = ROWS * PIX_W;
  localparam int unsigned BlkW = ADDR_W - ROW_IDX_W;
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLK_PER_FRAME - 1);
  localparam logic [ROW_IDX_W-1:0] LastRow = ROW_IDX_W'(ROWS - 1);

  logic [ROW_IDX_W-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d, mode_q, mode_d;
  logic [BlkW-1:0]      blk_q, blk_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 wr_fire, rd_fire;
  logic [RowW-1:0]      bank_row [2];
  logic [RowW-1:0]      bank_col [2];

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  jpeg_blk_bank #(.PIX_W(PIX_W)) u_bank0 (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wr_fire & ~wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_data_i (in_data),
    .rd_idx_i  (rd_row_q),
    .rd_row_o  (bank_row[0]),
    .rd_col_o  (bank_col[0])
  );

  jpeg_blk_bank #(.PIX_W(PIX_W)) u_bank1 (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wr_fire & wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_data_i (in_data),
    .rd_idx_i  (rd_row_q),
    .rd_row_o  (bank_row[1]),
    .rd_col_o  (bank_col[1])
  );

  // Fill and drain always hit different banks, so both updates may land in one cycle.
  always_comb begin
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    rd_row_d  = rd_row_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    mode_d    = mode_q;
    blk_d     = blk_q;
    addr_d    = addr_q;
    if (wr_fire) begin
      addr_d   = addr_q + ADDR_W'(1);
      wr_row_d = wr_row_q + ROW_IDX_W'(1);
      if (wr_row_q == LastRow) begin
        full_d[wr_bank_q] = 1'b1;
        mode_d[wr_bank_q] = transpose;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_row_d = rd_row_q + ROW_IDX_W'(1);
      if (rd_row_q == LastRow) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        blk_d             = (blk_q == BlkLast) ? '0 : blk_q + BlkW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_row_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_row_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      mode_q    <= '0;
      blk_q     <= '0;
      addr_q    <= '0;
    end else begin
      wr_row_q  <= wr_row_d;
      wr_bank_q <= wr_bank_d;
      rd_row_q  <= rd_row_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      blk_q     <= blk_d;
      addr_q    <= addr_d;
    end
  end

  assign out_data = mode_q[rd_bank_q] ? bank_col[rd_bank_q] : bank_row[rd_bank_q];
  assign out_row  = rd_row_q;
  assign out_blk  = blk_q;
  assign out_sob  = (rd_row_q == '0);
  assign out_eob  = (rd_row_q == LastRow);
  assign out_eof  = out_eob && (blk_q == BlkLast);
  assign in_addr  = addr_q;

endmodule
